// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 asynchronous serial receiver.
//   Oversamples the line at 16x the bit rate using a fractional baud accumulator.
//   Majority-votes three mid-bit samples, rejects start-bit glitches and checks
//   the stop bit. Bytes are delivered through a one-entry valid/ready register.
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous active-high reset
//   i_rx             raw serial line, idle high, asynchronous to i_clk
//   o_data[7:0]      received byte, stable while o_valid is high
//   o_valid          holding register full
//   i_ready          consumer accepts o_data when o_valid && i_ready
//   o_framing_error  one-cycle pulse when a stop bit is sampled low
//   o_overrun        one-cycle pulse when a completed byte is dropped
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQUENCY = 10000000,
  parameter int unsigned BAUD_RATE     = 57600,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_framing_error,
  output logic       o_overrun
);

  localparam logic [ACC_WIDTH-1:0] LP_INC = ACC_WIDTH'(16 * BAUD_RATE);
  localparam logic [ACC_WIDTH-1:0] LP_CLK = ACC_WIDTH'(CLK_FREQUENCY);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e               r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [3:0]           r_phase, w_phase_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [7:0]           r_shreg, w_shreg_nxt;
  logic                 r_s7, w_s7_nxt;
  logic                 r_s8, w_s8_nxt;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_framing_error;
  logic                 r_overrun;

  logic                 w_rx;
  logic [ACC_WIDTH-1:0] w_acc_sum;
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_end;
  logic                 w_vote;
  logic                 w_deliver;
  logic                 w_ferr;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end
  assign w_rx = r_sync[1];

  // Fractional accumulator: average tick rate is exactly 16*BAUD_RATE.
  assign w_acc_sum = r_acc + LP_INC;
  assign w_tick    = (w_acc_sum >= LP_CLK);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= w_acc_sum - LP_CLK;
    end else begin
      r_acc <= w_acc_sum;
    end
  end

  assign w_mid  = w_tick && (r_phase == 4'd9);
  assign w_end  = w_tick && (r_phase == 4'd15);
  // Third sample is the live synchronised value at the phase-9 tick.
  assign w_vote = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_phase   <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'd0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_s7      <= w_s7_nxt;
      r_s8      <= w_s8_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    w_s7_nxt      = r_s7;
    w_s8_nxt      = r_s8;
    w_deliver     = 1'b0;
    w_ferr        = 1'b0;

    if (w_tick) begin
      w_phase_nxt = r_phase + 4'd1;
      if (r_phase == 4'd7) w_s7_nxt = w_rx;
      if (r_phase == 4'd8) w_s8_nxt = w_rx;
    end

    unique case (r_state)
      StIdle: begin
        if (!w_rx) begin
          w_phase_nxt = 4'd0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (w_mid && w_vote) begin
          w_state_nxt = StIdle;
        end else if (w_end) begin
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = StData;
        end
      end
      StData: begin
        if (w_mid) begin
          w_shreg_nxt = {w_vote, r_shreg[7:1]};
        end
        if (w_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        // Leave at mid-stop-bit so the next start edge can be caught early.
        if (w_mid) begin
          if (w_vote) begin
            w_deliver   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = StBreak;
          end
        end
      end
      StBreak: begin
        // Wait out a held-low line so it cannot be decoded as 0x00 bytes.
        if (w_rx) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Holding register; a delivery wins over a same-cycle consume.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data          <= 8'd0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_framing_error <= w_ferr;
      r_overrun       <= w_deliver && r_valid && !i_ready;
      if (w_deliver) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data          = r_data;
  assign o_valid         = r_valid;
  assign o_framing_error = r_framing_error;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed testbench for uart_rx_deserializer at default parameters.
// Clock period is 100 time units (10 MHz); one nominal bit is 17361.1 units.
module tb_uart_rx_deserializer;

  localparam real CLK_T = 100.0;
  localparam real BIT_T = CLK_T * 10000000.0 / 57600.0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Event counters recorded outside reset; tasks compare deltas against expectations.
  int         n_valid = 0;
  int         n_fe = 0;
  int         n_ov = 0;
  logic [7:0] rxq[$];

  uart_rx_deserializer dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_rx            (rx),
    .o_data          (data),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_framing_error (framing_error),
    .o_overrun       (overrun)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) n_valid++;
      if (framing_error) n_fe++;
      if (overrun) n_ov++;
      if (valid && ready) rxq.push_back(data);
    end
  end

  initial begin
    #(100.0 * 95000.0);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop_bit;
    #(bit_t);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", framing_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", overrun); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL idle_data: got %h want 00", data); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL idle_fe: got %b want 0", framing_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL idle_ov: got %b want 0", overrun); end
  endtask

  task automatic test_single_byte();
    int q0, v0, f0, o0;
    logic [7:0] got;
    ready = 1'b1;
    q0 = rxq.size(); v0 = n_valid; f0 = n_fe; o0 = n_ov;
    send_byte(8'h55, 1'b1, BIT_T);
    settle();
    got = (rxq.size() > q0) ? rxq[q0] : 8'hxx;
    checks++; if (rxq.size() != q0 + 1) begin errors++; $display("FAIL single_count: got %0d want %0d", rxq.size() - q0, 1); end
    checks++; if (got !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", got); end
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", n_valid - v0); end
    checks++; if (n_fe != f0) begin errors++; $display("FAIL single_fe: got %0d pulses want 0", n_fe - f0); end
    checks++; if (n_ov != o0) begin errors++; $display("FAIL single_ov: got %0d pulses want 0", n_ov - o0); end
  endtask

  task automatic test_glitch();
    int q0, v0, f0;
    logic [7:0] got;
    q0 = rxq.size(); v0 = n_valid; f0 = n_fe;
    rx = 1'b0;
    repeat (40) @(posedge clk);
    rx = 1'b1;
    #(2.0 * BIT_T);
    checks++; if (n_valid != v0) begin errors++; $display("FAIL glitch_valid: got %0d cycles want 0", n_valid - v0); end
    checks++; if (n_fe != f0) begin errors++; $display("FAIL glitch_fe: got %0d pulses want 0", n_fe - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid_level: got %b want 0", valid); end
    send_byte(8'hA5, 1'b1, BIT_T);
    settle();
    got = (rxq.size() > q0) ? rxq[q0] : 8'hxx;
    checks++; if (rxq.size() != q0 + 1) begin errors++; $display("FAIL glitch_next_count: got %0d want 1", rxq.size() - q0); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL glitch_next_data: got %h want a5", got); end
  endtask

  task automatic test_framing_break();
    int q0, v0, f0, o0;
    logic [7:0] got;
    q0 = rxq.size(); v0 = n_valid; f0 = n_fe; o0 = n_ov;
    send_byte(8'hA3, 1'b0, BIT_T);
    #(3.0 * BIT_T);
    rx = 1'b1;
    #(BIT_T);
    checks++; if (n_fe - f0 != 1) begin errors++; $display("FAIL frame_fe: got %0d pulses want 1", n_fe - f0); end
    checks++; if (n_valid != v0) begin errors++; $display("FAIL frame_valid: got %0d cycles want 0", n_valid - v0); end
    checks++; if (n_ov != o0) begin errors++; $display("FAIL frame_ov: got %0d pulses want 0", n_ov - o0); end
    send_byte(8'h3C, 1'b1, BIT_T);
    settle();
    got = (rxq.size() > q0) ? rxq[q0] : 8'hxx;
    checks++; if (rxq.size() != q0 + 1) begin errors++; $display("FAIL frame_next_count: got %0d want 1", rxq.size() - q0); end
    checks++; if (got !== 8'h3C) begin errors++; $display("FAIL frame_next_data: got %h want 3c", got); end
  endtask

  task automatic test_overrun();
    int f0, o0;
    f0 = n_fe; o0 = n_ov;
    ready = 1'b0;
    #(BIT_T);
    send_byte(8'h11, 1'b1, BIT_T);
    send_byte(8'h22, 1'b1, BIT_T);
    settle();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b want 1", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL overrun_data: got %h want 11", data); end
    checks++; if (n_ov - o0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", n_ov - o0); end
    checks++; if (n_fe != f0) begin errors++; $display("FAIL overrun_fe: got %0d pulses want 0", n_fe - f0); end
    @(negedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL overrun_consume: got %b want 0", valid); end
  endtask

  task automatic test_back_to_back(input real bit_t, input string tag);
    logic [7:0] exp_b[4];
    logic [7:0] got;
    int q0, f0, o0;
    exp_b = '{8'h00, 8'hFF, 8'h80, 8'h01};
    ready = 1'b1;
    #(BIT_T);
    q0 = rxq.size(); f0 = n_fe; o0 = n_ov;
    for (int i = 0; i < 4; i++) send_byte(exp_b[i], 1'b1, bit_t);
    settle();
    checks++; if (rxq.size() != q0 + 4) begin errors++; $display("FAIL b2b_%s_count: got %0d want 4", tag, rxq.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      got = (rxq.size() > q0 + i) ? rxq[q0 + i] : 8'hxx;
      checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL b2b_%s_byte%0d: got %h want %h", tag, i, got, exp_b[i]); end
    end
    checks++; if (n_fe != f0) begin errors++; $display("FAIL b2b_%s_fe: got %0d pulses want 0", tag, n_fe - f0); end
    checks++; if (n_ov != o0) begin errors++; $display("FAIL b2b_%s_ov: got %0d pulses want 0", tag, n_ov - o0); end
  endtask

  task automatic test_reset_mid_byte();
    int q0, v0, f0;
    logic [7:0] pat;
    logic [7:0] got;
    ready = 1'b0;
    #(BIT_T);
    send_byte(8'h77, 1'b1, BIT_T);
    settle();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", valid); end
    pat = 8'hF0;
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      #(BIT_T);
    end
    rx = pat[4];
    #(0.5 * BIT_T);
    @(negedge clk);
    #10 reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmid_async_data: got %h want 00", data); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL rmid_async_fe: got %b want 0", framing_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_async_ov: got %b want 0", overrun); end
    repeat (5) @(posedge clk);
    #10 reset = 1'b0;
    v0 = n_valid; f0 = n_fe;
    // Remaining bits of 0xF0 and its stop bit are all high.
    #(6.0 * BIT_T);
    checks++; if (n_valid != v0) begin errors++; $display("FAIL rmid_partial_valid: got %0d cycles want 0", n_valid - v0); end
    checks++; if (n_fe != f0) begin errors++; $display("FAIL rmid_partial_fe: got %0d pulses want 0", n_fe - f0); end
    ready = 1'b1;
    q0 = rxq.size();
    send_byte(8'h5A, 1'b1, BIT_T);
    settle();
    got = (rxq.size() > q0) ? rxq[q0] : 8'hxx;
    checks++; if (rxq.size() != q0 + 1) begin errors++; $display("FAIL rmid_next_count: got %0d want 1", rxq.size() - q0); end
    checks++; if (got !== 8'h5A) begin errors++; $display("FAIL rmid_next_data: got %h want 5a", got); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_break();
    test_overrun();
    test_back_to_back(BIT_T, "nom");
    test_back_to_back(BIT_T / 1.03, "fast");
    test_back_to_back(BIT_T / 0.97, "slow");
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Asynchronous serial receiver for the host command link: it deserialises the `RX` pin into bytes for the command decoder inside `main`. It complements the existing `TX` path and uses the same 8N1 framing at `BAUD_RATE`. It oversamples the line 16× using a fractional baud accumulator, rejects start-bit glitches, majority-votes each bit and checks the stop bit. Bytes are delivered through a one-entry valid/ready holding register, with framing-error and overrun reporting.

## Interface
- `CLK_FREQUENCY`, default 10000000: frequency of `clk` in Hz.
- `BAUD_RATE`, default 57600: line rate in bit/s; 8 data bits, no parity, 1 stop bit, LSB first.
- `ACC_WIDTH`, default 32: baud accumulator width; must hold `CLK_FREQUENCY + 16*BAUD_RATE`.

Ports:
- `clk`  input  1  system clock; the single clock domain of the block.
- `reset`  input  1  asynchronous, active-high reset.
- `rx`  input  1  raw serial line, idle high, asynchronous to `clk`.
- `data`  output  8  received byte; stable while `valid` is high.
- `valid`  output  1  holding register full.
- `ready`  input  1  consumer accepts `data` on a cycle where `valid && ready`.
- `framing_error`  output  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- **Synchroniser:** `rx` passes through two flops before any use. Both flops reset to 1.
- **Oversample tick generator:**
  - Every `clk`, the accumulator adds `16*BAUD_RATE`.
  - When the sum is ≥ `CLK_FREQUENCY`, subtract `CLK_FREQUENCY` and assert `tick` for one cycle.
  - `tick` free-runs and is never re-phased.
- **Phase counter:** 4-bit `phase` counts ticks 0..15 within each bit. Samples are taken at phases 7, 8 and 9. The bit value is the majority of those three samples, decided at phase 9.
- **States:**
  - IDLE: on synchronised rx = 0, clear `phase` to 0 and go to START.
  - START: at phase 9, if the majority is 1 (a glitch), return to IDLE. Otherwise continue. At phase 15, clear the bit index and go to DATA.
  - DATA: at phase 9 of each bit, shift the majority into `shreg[7]` (right-shift, LSB first). At phase 15 of bit index 7, go to STOP.
  - STOP: at phase 9, if the majority is 1, deliver `shreg` and go to IDLE. If it is 0, pulse `framing_error`, discard the byte and go to BREAK.
  - BREAK: stay until synchronised rx = 1, then go to IDLE. This prevents a held-low line (break condition) from producing spurious bytes.
- **Early IDLE return:** the STOP→IDLE transition happens at phase 9, before the stop bit ends. This allows resynchronisation to the next start edge with up to roughly 6/16 bit of accumulated drift.
- **Delivery into the holding register:**
  - If `valid` is 0, or `valid && ready` in the same cycle: load `data`, set `valid` = 1.
  - Otherwise: keep the old `data`, pulse `overrun`, drop the new byte.
- **Consumption:** `valid && ready` with no simultaneous delivery clears `valid`. `data` holds its last value after `valid` clears.
- **`framing_error` and `overrun`:** never asserted in the same cycle, because delivery and the stop-bit error are mutually exclusive.
- **Reset:** asynchronous. Reset values are:
  - state = IDLE; `phase`, bit index, `shreg` and accumulator = 0.
  - `data` = 0, `valid` = 0, `framing_error` = 0, `overrun` = 0.
  - Synchroniser flops = 1.
  - A byte in flight is lost. Reception restarts on the first falling edge seen after reset deassertion.

## Timing
- **Input latency:** 2 `clk` cycles of synchroniser latency before IDLE sees an edge.
- **Start-edge uncertainty:** start detection is evaluated every `clk`, but `phase` advances only on `tick`. Start-edge uncertainty is therefore ≤ 1 tick (1/16 bit).
- **End-to-end latency:** `valid` rises on the `clk` edge after the STOP phase-9 tick. That is about 9 + 10/16 bit times plus 3 `clk` after the start falling edge at the pin.
- **Error pulses:** `framing_error` asserts in the same cycle position as `valid` would have. `overrun` asserts in the cycle of the dropped delivery. Each pulse lasts exactly one `clk`.
- **Handshake:** `ready` may be held high permanently; the block then never signals `overrun`. The handshake is fully synchronous and combinationally independent: `valid` does not depend on `ready` in the same cycle.
- **Default parameters:** 16× tick is about every 10.85 `clk`; one bit is about 173.6 `clk`. Long-term rate error is 0, because the accumulator is fractional.

## Test plan
- **Single byte:** reset, then send 0x55 at 57600 with `ready` = 1. Required: exactly one `valid` cycle with `data` = 0x55, and no error pulses.
- **Start-bit glitch:** drive `rx` low for 40 `clk`, then high. Required: no `valid`, no `framing_error`, state back in IDLE. A following 0xA5 is received correctly.
- **Framing error and break:** send 0xA3 with the stop bit low, then hold `rx` low for 3 bit times, then release. Required: one `framing_error` pulse, no `valid`, no further pulses during the break. A following 0x3C is received.
- **Overrun:** with `ready` = 0, send 0x11 then 0x22. Required: `valid` = 1 with `data` = 0x11, and one `overrun` pulse at the 0x22 stop bit. Raising `ready` clears `valid` after one cycle.
- **Back-to-back stress:** with `ready` = 1, send 0x00, 0xFF, 0x80, 0x01 with zero idle gap. Then repeat at line rates of +3% and −3% relative to `BAUD_RATE`. Required: all four bytes are received in order every time, with no errors.
- **Reset mid-byte:** assert `reset` in the middle of data bit 4 of 0xF0 for 5 `clk`. Required: all outputs are 0 immediately (asynchronously), and the partial byte is never delivered. A subsequent 0x5A is received correctly.
